// File: rtl/lsu_pkg.sv
// Shared types for the load/store controller: funct3 codes, FSM states,
// the latched request record and the misalignment rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Any code other than B/BU/H/HU behaves as a full word.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return lo[0];
      default:     return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: merges store data into a read word, and extracts /
// sign- or zero-extends load data from a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_extracted
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_merged    = i_rdata;
    o_extracted = i_rdata;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
        o_extracted = {{24{w_byte[7] & (i_funct3 == F3_B)}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_extracted = {{16{w_half[15] & (i_funct3 == F3_H)}}, w_half};
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between MEM stage and a word-addressed memory.
// Sub-word stores are read-modify-write. LSU_MISALIGN_TRAP_EN enables misalignment trapping.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_misalign,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_done,
  input  logic          mem_stall
);

  lsu_state_e  r_state, w_next;
  lsu_req_t    r_req;
  logic [31:0] r_mem_wdata, r_rdata;
  logic        r_misalign;
  logic        w_accept, w_mis, w_req_word;
  logic [31:0] w_merged, w_extracted;
  logic        w_unused_stall;

  assign w_unused_stall = mem_stall;
  assign w_accept       = req_valid & (r_state == S_IDLE);
  assign w_req_word     = !(req_funct3 inside {F3_B, F3_BU, F3_H, F3_HU});

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = lsu_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  lsu_lane_align u_align (
    .i_funct3    (r_req.funct3),
    .i_addr_lo   (r_req.addr[1:0]),
    .i_wdata     (r_req.wdata),
    .i_rdata     (mem_rdata),
    .o_merged    (w_merged),
    .o_extracted (w_extracted)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) begin
        if (w_mis)                    w_next = S_RSP;
        else if (req_we & w_req_word) w_next = S_WR;
        else                          w_next = S_RD;
      end
      S_RD:  if (mem_done) w_next = r_req.we ? S_WR : S_RSP;
      S_WR:  if (mem_done) w_next = S_RSP;
      S_RSP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    mem_rd    = (r_state == S_RD);
    mem_wr    = (r_state == S_WR);
    rsp_valid = (r_state == S_RSP);
  end

  // Request fields stay frozen from accept to response so the memory side sees stable values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req      <= '{we: req_we, funct3: req_funct3, addr: 32'(req_addr), wdata: req_wdata};
        r_rdata    <= '0;
        r_misalign <= w_mis;
        if (req_we & w_req_word) r_mem_wdata <= req_wdata;
      end
      if ((r_state == S_RD) && mem_done) begin
        if (r_req.we) r_mem_wdata <= w_merged;
        else          r_rdata     <= w_extracted;
      end
    end
  end

  assign mem_addr     = AW'({r_req.addr[31:2], 2'b00});
  assign mem_wdata    = r_mem_wdata;
  assign rsp_rdata    = r_rdata;
  assign rsp_misalign = r_misalign;

endmodule
